md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the execute stage of the 5-stage MIPS pipeline, alongside the ALU.
- Consumes the decoded md operation and the forwarded rs/rt operands, which are already muxed by the E-stage forwarding selects.
- Holds the HI/LO architectural registers and models multi-cycle latency through a busy counter.
- The hazard logic uses `busy`/`start` to stall the D stage when an md instruction follows one still in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd variants); must be ≥1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- md_op  input  4  decoded operation: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO (MADD/MADDU/MSUB/MSUBU only with MD_MADD_EN)
- en  input  1  E-stage instruction valid; low while E is flushed or a bubble
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- start  output  1  combinational; en & md_op is a MULT/DIV-class op & !busy
- busy  output  1  high while an operation is in flight
- hi  output  32  current HI register
- lo  output  32  current LO register
- md_out  output  32  combinational; hi when md_op=MFHI, lo when md_op=MFLO, else 0

Behaviour:
- Clock and reset:
  - One clock (`clk`); reset is asynchronous and active-high.
  - On reset: hi=0, lo=0, busy=0, cnt=0, and any pending result is discarded. This includes reset during an operation; nothing is written afterwards.
- Start edge (start=1 at a rising edge):
  - Compute the 64-bit result and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - busy = (cnt != 0), so busy goes high from the next cycle.
- Countdown and write-back:
  - cnt decrements every cycle while nonzero.
  - On the edge where cnt goes 1→0, write hi/lo from pending. busy falls in the same cycle the new values appear.
  - Total latency from the start edge to HI/LO visible: exactly N cycles.
- Arithmetic:
  - MULT: signed 32x32→64, {hi,lo}=product. MULTU: same, unsigned.
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend (rs).
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (rt=0): operation still busy for DIV_CYCLES; hi/lo left unchanged at completion.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - When en & !busy, write rs_val to hi/lo at the edge.
  - When busy, ignored; the hazard unit guarantees this never happens.
- Start while busy: ignored, since start is gated. The hazard logic must stall any md_op≠NONE in E or D while busy|start.
- MFHI/MFLO: read the current registers combinationally; a read in the same cycle as the completion edge returns the old value.
- en=0: no state change besides the countdown.

Optional Feature:
- MD_MADD_EN defined:
  - Adds MADD, MADDU, MSUB, MSUBU.
  - Pending result = {hi,lo} ± product, taking hi/lo as sampled at the start edge. Signed or unsigned product per op; 64-bit wrap-around.
  - Latency is MULT_CYCLES.
- Undefined: these encodings are treated as NONE (start=0, no effect).

Decomposition:
- Package md_pkg holds:
  - the md_op encodings (4-bit localparams);
  - default latency constants;
  - a helper predicate for "is MULT/DIV-class op", also used by the controller and hazard logic.
- Sub-module md_div_core is natural: signed/unsigned divider with sign fix-up, overflow and zero handling, producing {rem, quo}.
- Multiply and the counter stay inline.

Test Plan:
- MULT with rs=0xFFFFFFFE (−2), rt=3:
  - busy high for 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA;
  - MFHI/MFLO return these after busy falls.
- DIV with rs=0xFFFFFFF9 (−7), rt=2: after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same operands with DIVU: lo=0x7FFFFFFC, hi=1.
- DIVU by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO: busy 10 cycles; hi/lo remain 0x11/0x22.
- Reset asserted at cycle 3 of MULT 0x10000×0x10000: hi=lo=0 and busy=0 immediately; no later write.
- MTHI 0xABCD issued with busy=1: hi unchanged. Issued with busy=0: hi=0xABCD next cycle. MFLO in the completion cycle returns the old lo.
- (MD_MADD_EN) hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0. Without the macro, the same op leaves hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared md_op encodings, default latencies and the start-class predicate.
// The MD_MADD_EN macro enables the MADD/MADDU/MSUB/MSUBU family.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // True for ops that occupy the unit for a multi-cycle latency.
    function automatic logic md_is_start_op(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divider: signed/unsigned, MIPS sign rules, res_o = {rem, quo}.
// dz_o flags a zero divisor; res_o is then zero and must not be committed.
module md_div_core (
    input  logic        sgn_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        dz_o
);
    logic        neg_a, neg_b;
    logic [31:0] ua, ub, uq, ur, quo, rem;

    always_comb begin
        neg_a = sgn_i & a_i[31];
        neg_b = sgn_i & b_i[31];
        ua    = neg_a ? (32'd0 - a_i) : a_i;
        ub    = neg_b ? (32'd0 - b_i) : b_i;
        dz_o  = (b_i == 32'd0);
        uq    = dz_o ? 32'd0 : (ua / ub);
        ur    = dz_o ? 32'd0 : (ua % ub);
        // Quotient truncates toward zero; remainder follows the dividend sign.
        // 0x80000000 / -1 naturally wraps back to 0x80000000 with rem 0.
        quo   = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem   = neg_a ? (32'd0 - ur) : ur;
        res_o = {rem, quo};
    end
endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, busy countdown and deferred write-back.
// Define MD_MADD_EN to add the multiply-accumulate ops.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        en,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);
    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;
    logic             pwe_q, pwe_d;

    logic [63:0] prod_s, prod_u, div_res;
    logic        div_dz;

    md_div_core u_div (
        .sgn_i (md_op == MD_DIV),
        .a_i   (rs_val),
        .b_i   (rt_val),
        .res_o (div_res),
        .dz_o  (div_dz)
    );

    // Low 64 bits of a 64x64 product equal the 32x32 signed/unsigned product.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    assign busy  = (cnt_q != '0);
    assign start = en & md_is_start_op(md_op) & ~busy;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        md_out = 32'd0;
        if (md_op == MD_MFHI)      md_out = hi_q;
        else if (md_op == MD_MFLO) md_out = lo_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        pwe_d  = pwe_q;
        if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && pwe_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else if (start) begin
            cnt_d = CNT_W'(MULT_CYCLES);
            pwe_d = 1'b1;
            case (md_op)
                MD_MULT:  pend_d = prod_s;
                MD_MULTU: pend_d = prod_u;
                MD_DIV, MD_DIVU: begin
                    cnt_d  = CNT_W'(DIV_CYCLES);
                    pend_d = div_res;
                    pwe_d  = ~div_dz;
                end
`ifdef MD_MADD_EN
                MD_MADD:  pend_d = {hi_q, lo_q} + prod_s;
                MD_MADDU: pend_d = {hi_q, lo_q} + prod_u;
                MD_MSUB:  pend_d = {hi_q, lo_q} - prod_s;
                MD_MSUBU: pend_d = {hi_q, lo_q} - prod_u;
`endif
                default:  pwe_d = 1'b0;
            endcase
        end else if (en && md_op == MD_MTHI) begin
            hi_d = rs_val;
        end else if (en && md_op == MD_MTLO) begin
            lo_d = rs_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            pend_q <= 64'd0;
            pwe_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
            pwe_q  <= pwe_d;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit with hand-computed HI/LO results.
// Define MD_MADD_EN here too when the RTL is built with it.
module tb_md_unit;
    import md_pkg::*;

    logic        clk, reset, en, start, busy;
    logic [3:0]  md_op;
    logic [31:0] rs_val, rt_val, hi, lo, md_out;
    int          n_chk, n_err;
    logic        st_seen;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .en(en),
        .rs_val(rs_val), .rt_val(rt_val), .start(start), .busy(busy),
        .hi(hi), .lo(lo), .md_out(md_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single edge, then return to a bubble.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op; en = 1'b1; rs_val = a; rt_val = b;
        #1 st_seen = start;
        @(posedge clk);
        #1;
        md_op = MD_NONE; en = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic rd(input logic [3:0] op, input string tag, input logic [31:0] exp);
        md_op = op;
        #1 chk(tag, md_out, exp);
        md_op = MD_NONE;
    endtask

    initial begin
        int n;
        n_chk = 0; n_err = 0; st_seen = 1'b0;
        reset = 1'b1; en = 1'b0; md_op = MD_NONE; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        drive(MD_MULT, 32'hFFFFFFFE, 32'd3);
        chk("mult_start", {31'd0, st_seen}, 32'd1);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        rd(MD_MFHI, "mfhi", 32'hFFFFFFFF);
        rd(MD_MFLO, "mflo", 32'hFFFFFFFA);

        drive(MD_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        drive(MD_DIVU, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        chk("divu_lo", lo, 32'h7FFFFFFC);
        chk("divu_hi", hi, 32'd1);

        drive(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);

        drive(MD_MTHI, 32'h11, 32'd0);
        drive(MD_MTLO, 32'h22, 32'd0);
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);
        drive(MD_DIVU, 32'd100, 32'd0);
        chk("dz_busy", {31'd0, busy}, 32'd1);
        wait_idle(n);
        chk("dz_cycles", n, 32'd10);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        // Reset lands mid-operation; the pending product must never appear.
        drive(MD_MULT, 32'h10000, 32'h10000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        drive(MD_MULT, 32'd2, 32'd3);
        drive(MD_MTHI, 32'hABCD, 32'd0);
        chk("mthi_busy", hi, 32'd0);
        chk("start_gated", {31'd0, st_seen}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("pre_done_busy", {31'd0, busy}, 32'd1);
        rd(MD_MFLO, "mflo_old", 32'd0);
        @(posedge clk); #1;
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_lo", lo, 32'd6);
        drive(MD_MTHI, 32'hABCD, 32'd0);
        chk("mthi_idle", hi, 32'hABCD);

        drive(MD_MTHI, 32'd0, 32'd0);
        drive(MD_MTLO, 32'hFFFFFFFF, 32'd0);
        drive(MD_MADDU, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        chk("maddu_start", {31'd0, st_seen}, 32'd1);
        wait_idle(n);
        chk("maddu_cycles", n, 32'd5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`else
        chk("maddu_start", {31'd0, st_seen}, 32'd0);
        chk("maddu_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
